// File: rtl/seq_det_prog.sv
// Programmable serial sequence detector: matches a run-time configured bit pattern
// (up to MAX_LEN bits) in an accepted bit stream, with overlap control and a match counter.
module seq_det_prog #(
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned LEN_W   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               din_valid_i,
    input  logic               din_i,
    input  logic               cfg_we_i,
    input  logic [MAX_LEN-1:0] cfg_pattern_i,
    input  logic [LEN_W-1:0]   cfg_len_i,
    input  logic               cfg_overlap_i,
    input  logic               cnt_clr_i,
    output logic               match_o,
    output logic [CNT_W-1:0]   match_cnt_o,
    output logic [LEN_W-1:0]   fill_level_o
);

    localparam logic [LEN_W-1:0] MaxLenW = LEN_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};

    logic [MAX_LEN-1:0] pattern_q, pattern_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               overlap_q, overlap_d;
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic               match_q, match_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               accept;
    logic [MAX_LEN-1:0] hist_shift;
    logic [MAX_LEN-1:0] len_mask;
    logic [LEN_W-1:0]   fill_inc;
    logic               hit;

    assign accept     = din_valid_i & ~cfg_we_i;
    assign hist_shift = {hist_q[MAX_LEN-2:0], din_i};
    assign fill_inc   = (fill_q < len_q) ? fill_q + 1'b1 : len_q;

    // Only the low len bits of history and pattern take part in the compare.
    always_comb begin
        len_mask = '0;
        for (int i = 0; i < int'(MAX_LEN); i++) begin
            len_mask[i] = (i < int'(len_q));
        end
    end

    assign hit = accept && (len_q != '0) && (fill_inc == len_q) &&
                 ((hist_shift & len_mask) == (pattern_q & len_mask));

    always_comb begin
        pattern_d = pattern_q;
        len_d     = len_q;
        overlap_d = overlap_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        match_d   = hit;
        cnt_d     = cnt_q;

        if (cfg_we_i) begin
            pattern_d = cfg_pattern_i;
            len_d     = (cfg_len_i > MaxLenW) ? MaxLenW : cfg_len_i;
            overlap_d = cfg_overlap_i;
            hist_d    = '0;
            fill_d    = '0;
        end else if (din_valid_i) begin
            hist_d = hist_shift;
            fill_d = (hit && !overlap_q) ? '0 : fill_inc;
        end

        // Clear beats a coincident increment; the match pulse itself is unaffected.
        if (cnt_clr_i) begin
            cnt_d = '0;
        end else if (hit && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pattern_q <= '0;
            len_q     <= '0;
            overlap_q <= 1'b1;
            hist_q    <= '0;
            fill_q    <= '0;
            match_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            pattern_q <= pattern_d;
            len_q     <= len_d;
            overlap_q <= overlap_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            match_q   <= match_d;
            cnt_q     <= cnt_d;
        end
    end

    assign match_o      = match_q;
    assign match_cnt_o  = cnt_q;
    assign fill_level_o = fill_q;

endmodule
